// File: rtl/zero_scan_pkg.sv
// ============================================================================
// zero_scan_pkg : state encoding and width helpers for zero_scan_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package zero_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int calc_cnt_w(input int max_len, input int lanes);
    return $clog2(max_len * lanes + 1);
  endfunction

  // A single-element burst still needs a 1-bit index port.
  function automatic int calc_idx_w(input int max_len, input int lanes);
    return (max_len * lanes > 1) ? $clog2(max_len * lanes) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_zero_detect.sv
// ============================================================================
// lane_zero_detect : per-lane zero mask, zero popcount and lowest nonzero lane
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_zero_detect #(
  parameter  int DATA_W = 32,
  parameter  int LANE_W = 8,
  localparam int LANES  = DATA_W / LANE_W,
  localparam int LCNT_W = $clog2(LANES + 1),
  localparam int LSEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [DATA_W-1:0] i_word,
  output logic [LANES-1:0]  o_zero_mask,
  output logic [LCNT_W-1:0] o_zero_cnt,
  output logic              o_any_nz,
  output logic [LSEL_W-1:0] o_first_nz_lane
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign o_zero_mask[g] = (i_word[g*LANE_W +: LANE_W] == '0);
  end

  // Walking from the top lane down leaves the lowest nonzero lane selected.
  always_comb begin
    o_zero_cnt      = '0;
    o_first_nz_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (o_zero_mask[i]) begin
        o_zero_cnt = o_zero_cnt + LCNT_W'(1);
      end else begin
        o_first_nz_lane = LSEL_W'(i);
      end
    end
  end

  assign o_any_nz = ~&o_zero_mask;

endmodule

`default_nettype wire

// File: rtl/zero_scan_unit.sv
// ============================================================================
// zero_scan_unit : streaming burst zero detector (all-zero, zero count, first nonzero)
// Rev 1.0
// ============================================================================
`default_nettype none

module zero_scan_unit
  import zero_scan_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int LANE_W  = 8,
  parameter  int MAX_LEN = 16,
  localparam int LANES   = DATA_W / LANE_W,
  localparam int LEN_W   = calc_len_w(MAX_LEN),
  localparam int CNT_W   = calc_cnt_w(MAX_LEN, LANES),
  localparam int IDX_W   = calc_idx_w(MAX_LEN, LANES),
  localparam int LCNT_W  = $clog2(LANES + 1),
  localparam int LSEL_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              all_zero,
  output logic [CNT_W-1:0]  zero_cnt,
  output logic [IDX_W-1:0]  first_nz_idx
);

  if (DATA_W % LANE_W != 0) begin : g_width_check
    $error("zero_scan_unit: DATA_W must be a multiple of LANE_W");
  end

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   word_idx_q, word_idx_d;
  logic               found_q, found_d;
  logic               all_zero_q, all_zero_d;
  logic [CNT_W-1:0]   zero_cnt_q, zero_cnt_d;
  logic [IDX_W-1:0]   first_nz_idx_q, first_nz_idx_d;

  logic [LANES-1:0]   lane_zero_mask;
  logic [LCNT_W-1:0]  lane_zero_cnt;
  logic               lane_any_nz;
  logic [LSEL_W-1:0]  lane_first_nz;

  lane_zero_detect #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_detect (
    .i_word          (in_data),
    .o_zero_mask     (lane_zero_mask),
    .o_zero_cnt      (lane_zero_cnt),
    .o_any_nz        (lane_any_nz),
    .o_first_nz_lane (lane_first_nz)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    word_idx_d     = word_idx_q;
    found_d        = found_q;
    all_zero_d     = all_zero_q;
    zero_cnt_d     = zero_cnt_q;
    first_nz_idx_d = first_nz_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d          = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
          word_idx_d     = '0;
          found_d        = 1'b0;
          zero_cnt_d     = '0;
          first_nz_idx_d = '0;
          all_zero_d     = 1'b0;
          if (len == '0) begin
            all_zero_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          zero_cnt_d = zero_cnt_q + CNT_W'(lane_zero_cnt);
          if (!found_q && lane_any_nz) begin
            first_nz_idx_d = IDX_W'(word_idx_q) * IDX_W'(LANES) + IDX_W'(lane_first_nz);
            found_d        = 1'b1;
          end
          // all_zero is resolved on the last beat so it is valid in the done cycle.
          if (word_idx_q == len_q - LEN_W'(1)) begin
            all_zero_d = !found_q && (&lane_zero_mask);
            state_d    = ST_DONE;
          end else begin
            word_idx_d = word_idx_q + LEN_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      word_idx_q     <= '0;
      found_q        <= 1'b0;
      all_zero_q     <= 1'b0;
      zero_cnt_q     <= '0;
      first_nz_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      word_idx_q     <= word_idx_d;
      found_q        <= found_d;
      all_zero_q     <= all_zero_d;
      zero_cnt_q     <= zero_cnt_d;
      first_nz_idx_q <= first_nz_idx_d;
    end
  end

  assign in_ready     = (state_q == ST_RUN);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign all_zero     = all_zero_q;
  assign zero_cnt     = zero_cnt_q;
  assign first_nz_idx = first_nz_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_zero_scan_unit.sv
// ============================================================================
// tb_zero_scan_unit : directed scoreboard bench for zero_scan_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_zero_scan_unit;

  localparam int MAX_LEN = 16;
  localparam int LANES   = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [4:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, busy, done, all_zero;
  logic [6:0]  zero_cnt;
  logic [5:0]  first_nz_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       az;
    logic [6:0] cnt;
    logic [5:0] idx;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] words[$];

  zero_scan_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .all_zero     (all_zero),
    .zero_cnt     (zero_cnt),
    .first_nz_idx (first_nz_idx)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int eff);
    exp_t e;
    bit   found = 0;
    e.cnt = '0;
    e.idx = '0;
    for (int w = 0; w < eff; w++) begin
      for (int l = 0; l < LANES; l++) begin
        if (words[w][l*8 +: 8] == 8'h00) begin
          e.cnt = e.cnt + 7'd1;
        end else if (!found) begin
          found = 1;
          e.idx = 6'(w * LANES + l);
        end
      end
    end
    e.az = !found;
    return e;
  endfunction

  task automatic burst(input string tag, input int n_len, input bit gap, input bit poke);
    int   eff   = (n_len > MAX_LEN) ? MAX_LEN : n_len;
    int   beats = 0;
    int   cyc   = 0;
    int   widx  = 0;
    bit   last_was_beat = 0;
    exp_t e;
    sb.push_back(model(eff));
    start = 1'b1;
    len   = 5'(n_len);
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    while (!done && cyc < 100) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data  = (widx < words.size()) ? words[widx] : 32'hDEAD_BEEF;
      start    = poke && (cyc == 1);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      last_was_beat = in_valid && in_ready;
      if (last_was_beat) begin
        beats++;
        widx++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_beats"}, beats, eff);
    if (eff == 0) check({tag, "_done_latency"}, cyc, 0);
    else          check({tag, "_done_after_last_beat"}, last_was_beat, 1'b1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_all_zero"}, all_zero, e.az);
      check({tag, "_zero_cnt"}, zero_cnt, e.cnt);
      check({tag, "_first_nz"}, first_nz_idx, e.idx);
      start = poke;
      tick();
      start = 1'b0;
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
      tick();
      check({tag, "_no_queued_start"}, busy, 1'b0);
      check({tag, "_held_cnt"}, zero_cnt, e.cnt);
      check({tag, "_held_idx"}, first_nz_idx, e.idx);
      check({tag, "_held_az"}, all_zero, e.az);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_all_zero", all_zero, 1'b0);
    check("rst_cnt", zero_cnt, 0);
    check("rst_idx", first_nz_idx, 0);
    RESET = 1'b0;
    tick();

    words = '{32'h0, 32'h0, 32'h0};
    burst("len3_zero", 3, 1'b0, 1'b0);

    words = '{32'h0000_0000, 32'h00FF_0000};
    burst("len2_lane6", 2, 1'b0, 1'b0);

    words = '{32'h0101_0101, 32'h0101_0101, 32'h0101_0101, 32'h0101_0101};
    burst("len4_gaps", 4, 1'b1, 1'b0);

    words = '{};
    burst("len0", 0, 1'b0, 1'b0);

    words = '{};
    for (int i = 0; i < 20; i++) words.push_back((i == 5) ? 32'h0000_0100 : 32'h0);
    burst("len20_sat", 20, 1'b0, 1'b0);

    // Abort a burst after two beats with a mid-burst reset.
    start = 1'b1;
    len   = 5'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    tick();
    tick();
    in_valid = 1'b0;
    check("pre_reset_partial_cnt", zero_cnt, 6);
    RESET = 1'b1;
    tick();
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", in_ready, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_all_zero", all_zero, 1'b0);
    check("midrst_cnt", zero_cnt, 0);
    check("midrst_idx", first_nz_idx, 0);
    RESET = 1'b0;
    tick();
    check("post_rst_idle", busy, 1'b0);

    words = '{32'h0100_0000};
    burst("len1_lane3", 1, 1'b0, 1'b0);

    words = '{32'h0, 32'h8000_0000, 32'h0000_0001};
    burst("start_ignored", 3, 1'b0, 1'b1);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
